// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op encoding, FSM states, memory size
// and request classification helpers.
package lsu_pkg;

  localparam int MEM_BYTES_DEFAULT = 256;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } lsu_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    CAPTURE  = 3'd2,
    MERGE_WR = 3'd3,
    RESP     = 3'd4
  } lsu_state_e;

  function automatic logic is_load(input lsu_op_e op);
    logic res;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    logic res;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = off[0];
      OP_LW, OP_SW:         res = (off != 2'b00);
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane selection with sign/zero extension for loads, and lane merge
// of store data into a fetched word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane; offset 0 is the most significant byte
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (offset)
      2'b00:   byte_s = rdata[31:24];
      2'b01:   byte_s = rdata[23:16];
      2'b10:   byte_s = rdata[15:8];
      2'b11:   byte_s = rdata[7:0];
      default: byte_s = rdata[31:24];
    endcase
    if (offset[1]) begin
      half_s = rdata[15:0];
    end else begin
      half_s = rdata[31:16];
    end
  end

  // Extend the selected lane into the load result
  always_comb begin
    load_data = 32'h0000_0000;
    case (op)
      OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      OP_LH:   load_data = {{16{half_s[15]}}, half_s};
      OP_LW:   load_data = rdata;
      OP_LBU:  load_data = {24'h00_0000, byte_s};
      OP_LHU:  load_data = {16'h0000, half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Replace the target lane(s) of the fetched word with store data
  always_comb begin
    merged = rdata;
    case (op)
      OP_SB: begin
        case (offset)
          2'b00:   merged[31:24] = wdata[7:0];
          2'b01:   merged[23:16] = wdata[7:0];
          2'b10:   merged[15:8]  = wdata[7:0];
          2'b11:   merged[7:0]   = wdata[7:0];
          default: merged        = rdata;
        endcase
      end
      OP_SH: begin
        if (offset[1]) begin
          merged[15:0] = wdata[15:0];
        end else begin
          merged[31:16] = wdata[15:0];
        end
      end
      OP_SW:   merged = wdata;
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a big-endian, 1-cycle-latency
// data memory; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES - 3);

  lsu_state_e  state_r, state_s;
  lsu_op_e     op_r;
  lsu_op_e     req_op_s;
  logic [31:0] addr_r, wdata_r;
  logic        req_ready_r, req_ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic        resp_err_r, resp_err_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        mem_read_r, mem_read_s;
  logic        mem_write_r, mem_write_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic        accept_s, req_err_s;
  logic [31:0] load_data_s, merged_s;

  assign req_op_s  = lsu_op_e'(req_op);
  assign accept_s  = req_valid && req_ready_r && (state_r == IDLE);
  assign req_err_s = is_misaligned(req_op_s, req_addr[1:0]) ||
                     ({req_addr[31:2], 2'b00} >= ADDR_LIMIT);

  lsu_align u_align (
    .op        (op_r),
    .offset    (addr_r[1:0]),
    .rdata     (mem_rdata),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // Next state plus next value of every registered output
  always_comb begin
    state_s      = state_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'h0000_0000;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_wdata_s  = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else if (req_op_s == OP_SW) begin
            state_s     = ISSUE;
            mem_write_s = 1'b1;
            mem_wdata_s = req_wdata;
          end else begin
            state_s    = ISSUE;
            mem_read_s = 1'b1;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ISSUE: begin
        if (op_r == OP_SW) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: begin
        if (is_load(op_r)) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = load_data_s;
        end else begin
          // The merged word is held in the write-data register for MERGE_WR
          state_s     = MERGE_WR;
          mem_write_s = 1'b1;
          mem_wdata_s = merged_s;
        end
      end
      MERGE_WR: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, request latches and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      op_r         <= OP_LB;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_wdata_r  <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      mem_wdata_r  <= mem_wdata_s;
      if (accept_s) begin
        op_r    <= req_op_s;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end else begin
        op_r    <= op_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign mem_addr   = {addr_r[31:2], 2'b00};
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a big-endian
// registered-read memory model.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011,
                         LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_init = 1'b1;
  logic [31:0] mem [0:63];

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, registered read, preloaded while mem_init is high
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[0]  <= 32'h0011_10AA;
      mem[1]  <= 32'h80F0_7F81;
      mem[63] <= 32'hCAFE_F00D;
    end else begin
      if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (resp_valid) resp_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic busy);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.busy = busy;
    if (exp_err) begin
      v.exp_lat = 1; v.exp_rd = 0; v.exp_wr = 0;
    end else if (op == SW) begin
      v.exp_lat = 2; v.exp_rd = 0; v.exp_wr = 1;
    end else if (op == SB || op == SH) begin
      v.exp_lat = 4; v.exp_rd = 1; v.exp_wr = 1;
    end else begin
      v.exp_lat = 3; v.exp_rd = 1; v.exp_wr = 0;
    end
    return v;
  endfunction

  // Issue one request (called at posedge+1) and check the full transaction
  task automatic run_vec(input string tag, input vec_t v);
    int n, lat, rd0, wr0, both0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    if (v.busy) begin
      req_op = SW; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_idle_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(v.exp_rd));
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
    chk({tag, "_rd_wr_overlap"}, 32'(both_cnt - both0), 32'h0);
  endtask

  initial begin
    int wr0, resp0;
    vec_t v;

    vecs.push_back(mk(LB,  32'd3,   32'h0,         32'hFFFF_FFAA, 1'b0, 1'b0));
    vecs.push_back(mk(LBU, 32'd3,   32'h0,         32'h0000_00AA, 1'b0, 1'b0));
    vecs.push_back(mk(LH,  32'd2,   32'h0,         32'h0000_10AA, 1'b0, 1'b0));
    vecs.push_back(mk(LW,  32'd0,   32'h0,         32'h0011_10AA, 1'b0, 1'b0));
    vecs.push_back(mk(LB,  32'd1,   32'h0,         32'h0000_0011, 1'b0, 1'b0));
    vecs.push_back(mk(LHU, 32'd0,   32'h0,         32'h0000_0011, 1'b0, 1'b0));
    vecs.push_back(mk(LH,  32'd4,   32'h0,         32'hFFFF_80F0, 1'b0, 1'b0));
    vecs.push_back(mk(LHU, 32'd6,   32'h0,         32'h0000_7F81, 1'b0, 1'b0));
    vecs.push_back(mk(LB,  32'd5,   32'h0,         32'hFFFF_FFF0, 1'b0, 1'b0));
    vecs.push_back(mk(LB,  32'd6,   32'h0,         32'h0000_007F, 1'b0, 1'b0));
    vecs.push_back(mk(SB,  32'd1,   32'h0000_0055, 32'h0,         1'b0, 1'b0));
    vecs.push_back(mk(LW,  32'd0,   32'h0,         32'h0055_10AA, 1'b0, 1'b0));
    vecs.push_back(mk(SH,  32'd6,   32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0));
    vecs.push_back(mk(LW,  32'd4,   32'h0,         32'h80F0_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk(SW,  32'd8,   32'h1234_5678, 32'h0,         1'b0, 1'b0));
    vecs.push_back(mk(SB,  32'd10,  32'h0000_00AB, 32'h0,         1'b0, 1'b0));
    vecs.push_back(mk(LW,  32'd8,   32'h0,         32'h1234_AB78, 1'b0, 1'b0));
    vecs.push_back(mk(LW,  32'd2,   32'h0,         32'h0,         1'b1, 1'b0));
    vecs.push_back(mk(SH,  32'd5,   32'h0000_FFFF, 32'h0,         1'b1, 1'b0));
    vecs.push_back(mk(LW,  32'd256, 32'h0,         32'h0,         1'b1, 1'b0));
    vecs.push_back(mk(SB,  32'd256, 32'h0000_0001, 32'h0,         1'b1, 1'b0));
    vecs.push_back(mk(LW,  32'd252, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0));
    vecs.push_back(mk(LB,  32'd253, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0));
    vecs.push_back(mk(LW,  32'd0,   32'h0,         32'h0055_10AA, 1'b0, 1'b1));
    vecs.push_back(mk(LW,  32'd0,   32'h0,         32'h0055_10AA, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the CAPTURE cycle of an SH: write dropped, no response
    wr0 = wr_cnt; resp0 = resp_cnt;
    req_valid = 1'b1; req_op = SH; req_addr = 32'd4; req_wdata = 32'h0000_1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_after", {31'h0, req_ready}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_writes", 32'(wr_cnt - wr0), 32'h0);
    chk("midrst_no_resp", 32'(resp_cnt - resp0), 32'h0);
    v = mk(LW, 32'd4, 32'h0, 32'h80F0_BEEF, 1'b0, 1'b0);
    run_vec("midrst_reread", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256, giving the data-memory size in bytes; any access whose word address is not below MEM_BYTES-3 is out of range.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, core request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_op, input, 3, encoded as 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-justified for SB/SH.
REQ-009 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, extended load result, 0 for stores and errors.
REQ-011 SHALL have port resp_err, output, 1, misaligned or out-of-range access.
REQ-012 SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32), which connect to the data memory.
REQ-013 SHALL treat the data memory as big-endian and byte-addressed, with the byte at the word address in bits 31:24 and a registered read latency of 1 cycle.

Function
REQ-014 SHALL use FSM states IDLE, ISSUE, CAPTURE, MERGE_WR and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge with req_valid and req_ready both high, and op, addr and wdata are latched at that edge.
REQ-016 SHALL always drive mem_addr = {latched_addr[31:2],2'b00}.
REQ-017 SHALL treat misalignment as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-018 SHALL handle a misaligned or out-of-range request with no memory access: IDLE->RESP, with resp_err=1 and resp_rdata=0.
REQ-019 SHALL for loads: ISSUE drives mem_read=1; CAPTURE selects and extends from mem_rdata into the response register; then RESP; resp_valid rises 3 cycles after the accept edge.
REQ-020 SHALL select load data as follows: byte lane at offset k is mem_rdata[31-8k -: 8]; a halfword at offset 0 is bits 31:16 and at offset 2 is bits 15:0.
REQ-021 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results.
REQ-022 SHALL for SW: ISSUE drives mem_write=1 with mem_wdata=req_wdata, then RESP; resp_valid rises 2 cycles after accept.
REQ-023 SHALL for SB/SH do read-modify-write: ISSUE reads; CAPTURE registers the merged word (target lane(s) replaced by wdata[7:0] or wdata[15:0], other bytes preserved); MERGE_WR drives mem_write=1; then RESP; resp_valid rises 4 cycles after accept.
REQ-024 SHALL hold resp_valid high for exactly one cycle in RESP, then return to IDLE; responses have no back-pressure.
REQ-025 SHALL never assert mem_read and mem_write in the same cycle, and SHALL assert each for at most one cycle per request.
REQ-026 SHALL ignore req_valid while not in IDLE, with no queuing.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, enter IDLE and clear all outputs: req_ready, resp_valid, resp_err, mem_read, mem_write, mem_addr, mem_wdata and resp_rdata all 0.
REQ-028 SHALL, when reset arrives mid-operation, abandon the request with no response and no mem_write in the cycle after reset; a pending RMW write is dropped in full.
REQ-029 SHALL assert req_ready in the first cycle after rst_n returns high.

Structure
REQ-030 SHALL place the op encoding enum, FSM state enum and MEM_BYTES default in shared package lsu_pkg.
REQ-031 SHALL implement lane selection/extension and store merge in one combinational sub-module, lsu_align, instantiated once.

Verification
REQ-032 SHALL cover: memory word 0 = 0x001110AA; LB addr 3 -> resp_rdata 0xFFFFFFAA; LBU addr 3 -> 0x000000AA; resp_valid 3 cycles after accept.
REQ-033 SHALL cover: LH addr 2 on word 0x001110AA -> 0x000010AA, and LW addr 0 -> 0x001110AA, resp_err=0 in both cases.
REQ-034 SHALL cover: SB addr 1 wdata 0x00000055, then LW addr 0 -> 0x005510AA; the SB response arrives 4 cycles after accept, with a single mem_write.
REQ-035 SHALL cover: LW addr 2 and SH addr 5 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, with mem_read and mem_write never asserted.
REQ-036 SHALL cover: LW addr 256 with MEM_BYTES=256 -> resp_err=1, with no memory access.
REQ-037 SHALL cover: rst_n low during the CAPTURE cycle of an SH -> no mem_write and no resp_valid; word unchanged on re-read.
